// File: rtl/goertzel_harmonic_analyzer_pkg.sv
// Shared types, constants and helpers for the Goertzel harmonic analyzer.
package goertzel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    UPDATE,
    FINAL,
    DONE
  } state_e;

  // Coefficients are Q2.16, so products are rescaled by this many bits.
  localparam int Q_SHIFT = 16;

  // Widest intermediate the wrap check has to look at.
  localparam int WIDE = 128;

  // True when v does not fit in 'width' bits: as two's complement when
  // as_signed is set, otherwise as an unsigned value.
  function automatic logic wraps(input logic signed [WIDE-1:0] v,
                                 input int unsigned width,
                                 input logic as_signed);
    logic signed [WIDE-1:0] hi;
    if (as_signed) begin
      hi = v >>> (width - 1);
      return !((hi == '0) || (hi == '1));
    end
    hi = v >>> width;
    return hi != '0;
  endfunction

endpackage

// File: rtl/goertzel_harmonic_analyzer_if.sv
// Control, sample and result bundle of the harmonic analyzer.
interface goertzel_harmonic_analyzer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_HARM     = 5,
  parameter int COEF_WIDTH = 18,
  parameter int POW_WIDTH  = 80
);
  logic                         start;
  logic                         sample_valid;
  logic                         sample_ready;
  logic [DATA_WIDTH-1:0]        sample_in;
  logic [N_HARM*COEF_WIDTH-1:0] coef_in;
  logic                         busy;
  logic                         done;
  logic [N_HARM*POW_WIDTH-1:0]  power_out;
  logic                         overflow;

  modport master (
    output start, sample_valid, sample_in, coef_in,
    input  sample_ready, busy, done, power_out, overflow
  );

  modport slave (
    input  start, sample_valid, sample_in, coef_in,
    output sample_ready, busy, done, power_out, overflow
  );
endinterface

// File: rtl/goertzel_harmonic_analyzer_mac.sv
// Shared Goertzel arithmetic: state recursion for UPDATE, bin power for FINAL.
module goertzel_mac
  import goertzel_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 18,
  parameter int ACC_WIDTH  = 40,
  parameter int POW_WIDTH  = 80
) (
  input  logic                        final_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  input  logic signed [COEF_WIDTH-1:0] coef_i,
  input  logic signed [ACC_WIDTH-1:0]  s1_i,
  input  logic signed [ACC_WIDTH-1:0]  s2_i,
  output logic signed [ACC_WIDTH-1:0]  s0_o,
  output logic        [POW_WIDTH-1:0]  pow_o,
  output logic                         ovf_o
);
  localparam int PW = COEF_WIDTH + ACC_WIDTH;         // full c*s1 product
  localparam int SW = PW + 2;                         // s0 before truncation
  localparam int QW = 2 * ACC_WIDTH + COEF_WIDTH + 2; // power before truncation

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] scaled;
  logic signed [SW-1:0] s0_full;
  logic signed [QW-1:0] p_full;

  // Full-precision product, floored back to the state's binary point.
  assign prod   = PW'(coef_i) * PW'(s1_i);
  assign scaled = prod >>> Q_SHIFT;

  assign s0_full = SW'(x_i) + SW'(scaled) - SW'(s2_i);
  assign p_full  = QW'(s1_i) * QW'(s1_i) + QW'(s2_i) * QW'(s2_i)
                 - QW'(scaled) * QW'(s2_i);

  assign s0_o  = ACC_WIDTH'(s0_full);
  assign pow_o = POW_WIDTH'(p_full);
  assign ovf_o = final_i ? wraps(WIDE'(p_full), POW_WIDTH, 1'b0)
                         : wraps(WIDE'(s0_full), ACC_WIDTH, 1'b1);
endmodule

// File: rtl/goertzel_harmonic_analyzer.sv
// Block Goertzel analyzer: one time-multiplexed MAC walks all bins per sample,
// then walks them again to produce per-bin squared magnitude.
module goertzel_harmonic_analyzer
  import goertzel_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_HARM     = 5,
  parameter int BLOCK_LEN  = 480,
  parameter int COEF_WIDTH = 18,
  parameter int ACC_WIDTH  = 40,
  parameter int POW_WIDTH  = 2 * ACC_WIDTH
) (
  input logic clk,
  input logic rst_n,
  goertzel_harmonic_analyzer_if.slave bus
);
  localparam int KW = (N_HARM > 1) ? $clog2(N_HARM) : 1;
  localparam int CW = $clog2(BLOCK_LEN + 1);

  state_e                         state_q;
  logic                           ready_q;
  logic                           busy_q;
  logic                           done_q;
  logic                           ovf_q;
  logic [N_HARM*POW_WIDTH-1:0]    power_q;
  logic signed [DATA_WIDTH-1:0]   sample_q;
  logic [KW-1:0]                  k_q;
  logic [CW-1:0]                  count_q;
  logic signed [ACC_WIDTH-1:0]    s1_q [N_HARM];
  logic signed [ACC_WIDTH-1:0]    s2_q [N_HARM];

  logic signed [COEF_WIDTH-1:0]   coef_k;
  logic signed [ACC_WIDTH-1:0]    mac_s0;
  logic        [POW_WIDTH-1:0]    mac_pow;
  logic                           mac_ovf;
  logic                           last_bin;

  assign coef_k   = bus.coef_in[k_q*COEF_WIDTH +: COEF_WIDTH];
  assign last_bin = (k_q == KW'(N_HARM - 1));

  goertzel_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .COEF_WIDTH(COEF_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .POW_WIDTH (POW_WIDTH)
  ) u_mac (
    .final_i(state_q == FINAL),
    .x_i    (sample_q),
    .coef_i (coef_k),
    .s1_i   (s1_q[k_q]),
    .s2_i   (s2_q[k_q]),
    .s0_o   (mac_s0),
    .pow_o  (mac_pow),
    .ovf_o  (mac_ovf)
  );

  // Block sequencer: sample handshake, per-bin recursion, per-bin power.
  // NOTE: every register here uses <= so the MAC always sees pre-edge s1/s2 and
  // the bin counter and state advance together without ordering hazards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      power_q  <= '0;
      sample_q <= '0;
      k_q      <= '0;
      count_q  <= '0;
      // NOTE: the bin state arrays are tiny and an abort must leave them zero,
      // so they sit on the async reset like every other register.
      for (int i = 0; i < N_HARM; i++) begin
        s1_q[i] <= '0;
        s2_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= ACCUM;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            ovf_q   <= 1'b0;
            count_q <= '0;
            k_q     <= '0;
            for (int i = 0; i < N_HARM; i++) begin
              s1_q[i] <= '0;
              s2_q[i] <= '0;
            end
          end
        end
        ACCUM: begin
          if (bus.sample_valid && ready_q) begin
            sample_q <= bus.sample_in;
            count_q  <= count_q + CW'(1);
            ready_q  <= 1'b0;
            k_q      <= '0;
            state_q  <= UPDATE;
          end
        end
        UPDATE: begin
          s2_q[k_q] <= s1_q[k_q];
          s1_q[k_q] <= mac_s0;
          if (mac_ovf) ovf_q <= 1'b1;
          if (last_bin) begin
            k_q <= '0;
            if (count_q == CW'(BLOCK_LEN)) begin
              state_q <= FINAL;
            end else begin
              state_q <= ACCUM;
              ready_q <= 1'b1;
            end
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        FINAL: begin
          power_q[k_q*POW_WIDTH +: POW_WIDTH] <= mac_pow;
          if (mac_ovf) ovf_q <= 1'b1;
          if (last_bin) begin
            k_q     <= '0;
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sample_ready = ready_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.power_out    = power_q;
  assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_goertzel_harmonic_analyzer.sv
// Randomized bench for the Goertzel analyzer against a block-level reference model.
module tb_goertzel_harmonic_analyzer;
  localparam int N_A  = 5;
  localparam int BL_A = 480;
  localparam int BL_B = 4;
  localparam int BL_C = 64;

  logic clk;
  logic rst_n;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model inputs and outputs.
  int                samp_q[$];
  int                coef_m [N_A];
  logic [127:0]      exp_pow [N_A];
  bit                exp_ovf;

  goertzel_harmonic_analyzer_if #(.DATA_WIDTH(16), .N_HARM(5), .COEF_WIDTH(18), .POW_WIDTH(80)) ifa ();
  goertzel_harmonic_analyzer_if #(.DATA_WIDTH(16), .N_HARM(1), .COEF_WIDTH(18), .POW_WIDTH(80)) ifb ();
  goertzel_harmonic_analyzer_if #(.DATA_WIDTH(16), .N_HARM(1), .COEF_WIDTH(18), .POW_WIDTH(40)) ifc ();

  goertzel_harmonic_analyzer #(.DATA_WIDTH(16), .N_HARM(5), .BLOCK_LEN(BL_A), .COEF_WIDTH(18),
    .ACC_WIDTH(40), .POW_WIDTH(80)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  goertzel_harmonic_analyzer #(.DATA_WIDTH(16), .N_HARM(1), .BLOCK_LEN(BL_B), .COEF_WIDTH(18),
    .ACC_WIDTH(40), .POW_WIDTH(80)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  goertzel_harmonic_analyzer #(.DATA_WIDTH(16), .N_HARM(1), .BLOCK_LEN(BL_C), .COEF_WIDTH(18),
    .ACC_WIDTH(20), .POW_WIDTH(40)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic signed [127:0] floor_q16(input logic signed [127:0] v);
    logic signed [127:0] q;
    q = v / 65536;
    if (v < 0 && q * 65536 != v) q = q - 1;
    return q;
  endfunction

  function automatic logic signed [127:0] wrap_to(input logic signed [127:0] v, input int w);
    logic signed [127:0] span;
    logic signed [127:0] m;
    span = 128'sd1 <<< w;
    m = v % span;
    if (m < 0) m = m + span;
    if (m >= span / 2) m = m - span;
    return m;
  endfunction

  // Each bin processed over the whole block on its own, then its power.
  function automatic void run_model(input int nh, input int acc_w, input int pow_w);
    logic signed [127:0] s0, s1, s2, ws, c, p, pm, span;
    exp_ovf = 1'b0;
    for (int k = 0; k < nh; k++) begin
      s1 = 0;
      s2 = 0;
      c  = coef_m[k];
      foreach (samp_q[i]) begin
        s0 = samp_q[i] + floor_q16(c * s1) - s2;
        ws = wrap_to(s0, acc_w);
        if (ws != s0) exp_ovf = 1'b1;
        s2 = s1;
        s1 = ws;
      end
      p    = s1 * s1 + s2 * s2 - floor_q16(c * s1) * s2;
      span = 128'sd1 <<< pow_w;
      pm   = p % span;
      if (pm < 0) pm = pm + span;
      if (pm != p) exp_ovf = 1'b1;
      exp_pow[k] = pm;
    end
  endfunction

  function automatic void fill_random(input int len, input int mag);
    samp_q.delete();
    for (int i = 0; i < len; i++) samp_q.push_back(int'($urandom_range(0, 2 * mag)) - mag);
  endfunction

  task automatic load_coef_a();
    for (int k = 0; k < N_A; k++) ifa.coef_in[k*18 +: 18] = coef_m[k][17:0];
  endtask

  // ---------------- block driver for the 5-bin instance ----------------
  task automatic run_block_a(input bit gaps, input bit poke, input int stop_after, input bit chain);
    int n_hs, since, pat_err;
    bit hs, finished, poked, exp_ready;
    n_hs = 0; since = -1; pat_err = 0; finished = 0; poked = 0;
    load_coef_a();
    ifa.sample_valid = 1'b0;
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    n_cmp++;
    if (ifa.busy !== 1'b1 || ifa.sample_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL a_start_ack: busy=%b ready=%b, need 1 1", ifa.busy, ifa.sample_ready);
    end
    n_cmp++;
    if (ifa.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL a_ovf_clear: overflow=%b, need 0", ifa.overflow);
    end
    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      if (n_hs < BL_A && (!gaps || $urandom_range(0, 3) != 0)) begin
        ifa.sample_valid = 1'b1;
        ifa.sample_in    = 16'(samp_q[n_hs]);
      end else begin
        ifa.sample_valid = 1'b0;
        ifa.sample_in    = 16'($urandom);
      end
      if (poke && !poked && ifa.sample_ready && n_hs >= 3) begin
        ifa.start = 1'b1;
        poked = 1'b1;
      end
      hs = ifa.sample_valid && ifa.sample_ready;
      @(posedge clk); #1;
      ifa.start = 1'b0;
      if (hs) begin
        n_hs++;
        since = 0;
      end else if (since >= 0) begin
        since++;
      end
      if (stop_after > 0 && n_hs == stop_after) begin
        ifa.sample_valid = 1'b0;
        return;
      end
      exp_ready = (n_hs < BL_A) && (since < 0 || since >= N_A);
      if (ifa.sample_ready !== exp_ready) pat_err++;
      if (n_hs == BL_A && since == 2 * N_A) finished = 1'b1;
      else if (ifa.done !== 1'b0 || ifa.busy !== 1'b1) pat_err++;
    end
    ifa.sample_valid = 1'b0;
    n_cmp++;
    if (!finished) begin
      n_bad++;
      $display("FAIL a_timeout: handshakes=%0d, need %0d then done", n_hs, BL_A);
    end
    n_cmp++;
    if (ifa.done !== 1'b1 || ifa.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL a_done_timing: done=%b busy=%b 2N after last sample, need 1 0", ifa.done, ifa.busy);
    end
    n_cmp++;
    if (pat_err != 0) begin
      n_bad++;
      $display("FAIL a_handshake_pattern: %0d bad cycles, need 0", pat_err);
    end
    run_model(N_A, 40, 80);
    for (int k = 0; k < N_A; k++) begin
      n_cmp++;
      if (ifa.power_out[k*80 +: 80] !== exp_pow[k][79:0]) begin
        n_bad++;
        $display("FAIL a_power[%0d]: got %h, need %h", k, ifa.power_out[k*80 +: 80], exp_pow[k][79:0]);
      end
    end
    n_cmp++;
    if (ifa.overflow !== exp_ovf) begin
      n_bad++;
      $display("FAIL a_overflow: got %b, need %b", ifa.overflow, exp_ovf);
    end
    if (!chain) begin
      @(posedge clk); #1;
      n_cmp++;
      if (ifa.done !== 1'b0 || ifa.power_out[79:0] !== exp_pow[0][79:0]) begin
        n_bad++;
        $display("FAIL a_hold: done=%b power0=%h, need 0 %h", ifa.done, ifa.power_out[79:0], exp_pow[0][79:0]);
      end
    end
  endtask

  // ---------------- single-bin instances ----------------
  task automatic run_b();
    int n;
    bit hs, got;
    n = 0; got = 0;
    ifb.coef_in = coef_m[0][17:0];
    ifb.start = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    for (int cyc = 0; cyc < 2000 && !got; cyc++) begin
      ifb.sample_valid = (n < samp_q.size());
      if (n < samp_q.size()) ifb.sample_in = 16'(samp_q[n]);
      hs = ifb.sample_valid && ifb.sample_ready;
      @(posedge clk); #1;
      if (hs) n++;
      if (ifb.done === 1'b1) got = 1'b1;
    end
    ifb.sample_valid = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL b_timeout: done not seen, %0d samples taken", n);
    end
    run_model(1, 40, 80);
    n_cmp++;
    if (ifb.power_out !== exp_pow[0][79:0] || ifb.overflow !== exp_ovf) begin
      n_bad++;
      $display("FAIL b_model: got %h/%b, need %h/%b", ifb.power_out, ifb.overflow, exp_pow[0][79:0], exp_ovf);
    end
  endtask

  task automatic run_c();
    int n;
    bit hs, got;
    n = 0; got = 0;
    ifc.coef_in = coef_m[0][17:0];
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    n_cmp++;
    if (ifc.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL c_ovf_clear: overflow=%b after start, need 0", ifc.overflow);
    end
    for (int cyc = 0; cyc < 2000 && !got; cyc++) begin
      ifc.sample_valid = (n < samp_q.size());
      if (n < samp_q.size()) ifc.sample_in = 16'(samp_q[n]);
      hs = ifc.sample_valid && ifc.sample_ready;
      @(posedge clk); #1;
      if (hs) n++;
      if (ifc.done === 1'b1) got = 1'b1;
    end
    ifc.sample_valid = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL c_timeout: done not seen, %0d samples taken", n);
    end
    run_model(1, 20, 40);
    n_cmp++;
    if (ifc.power_out !== exp_pow[0][39:0] || ifc.overflow !== exp_ovf) begin
      n_bad++;
      $display("FAIL c_model: got %h/%b, need %h/%b", ifc.power_out, ifc.overflow, exp_pow[0][39:0], exp_ovf);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_cmp++;
    if (ifa.sample_ready !== 1'b0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: ready=%b busy=%b done=%b, need 0 0 0", ifa.sample_ready, ifa.busy, ifa.done);
    end
    n_cmp++;
    if (ifa.power_out !== '0 || ifa.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_data: power=%h ovf=%b, need 0 0", ifa.power_out, ifa.overflow);
    end
    n_cmp++;
    if (ifb.power_out !== '0 || ifc.power_out !== '0 || ifb.busy !== 1'b0 || ifc.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_small: b=%h c=%h, need 0 0", ifb.power_out, ifc.power_out);
    end
  endtask

  task automatic test_small_block();
    samp_q = '{1000, 0, -1000, 0};
    coef_m[0] = 0;
    run_b();
    n_cmp++;
    if (ifb.power_out !== 80'd4000000 || ifb.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL small_block: got %0d/%b, need 4000000/0", ifb.power_out, ifb.overflow);
    end
  endtask

  task automatic test_zero_block();
    fill_random(BL_A, 0);
    for (int k = 0; k < N_A; k++) coef_m[k] = int'($urandom_range(0, 262143)) - 131072;
    run_block_a(1'b0, 1'b0, 0, 1'b0);
    n_cmp++;
    if (ifa.power_out !== '0) begin
      n_bad++;
      $display("FAIL zero_block: power=%h, need 0", ifa.power_out);
    end
  endtask

  task automatic test_continuous_valid();
    real pi;
    pi = 3.14159265358979;
    for (int k = 0; k < N_A; k++) coef_m[k] = int'(2.0 * $cos(2.0 * pi * (k + 1) / BL_A) * 65536.0);
    fill_random(BL_A, 32768);
    run_block_a(1'b0, 1'b0, 0, 1'b1);
  endtask

  // Starts in the very cycle done is high.
  task automatic test_back_to_back();
    fill_random(BL_A, 20000);
    run_block_a(1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_start_ignored();
    for (int k = 0; k < N_A; k++) coef_m[k] = int'($urandom_range(0, 262143)) - 131072;
    fill_random(BL_A, 32768);
    run_block_a(1'b1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_block();
    fill_random(BL_A, 32768);
    run_block_a(1'b1, 1'b0, 100, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++;
    if (ifa.sample_ready !== 1'b0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0 ||
        ifa.power_out !== '0 || ifa.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: ready=%b busy=%b done=%b ovf=%b power=%h, need all 0",
               ifa.sample_ready, ifa.busy, ifa.done, ifa.overflow, ifa.power_out);
    end
    fill_random(BL_A, 32768);
    run_block_a(1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_overflow();
    samp_q.delete();
    for (int i = 0; i < BL_C; i++) samp_q.push_back(30000);
    coef_m[0] = 'h20000;
    coef_m[0] = coef_m[0] - 262144;
    run_c();
    n_cmp++;
    if (ifc.overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_set: got %b, need 1", ifc.overflow);
    end
    fill_random(BL_C, 50);
    coef_m[0] = int'($urandom_range(0, 40000)) - 20000;
    run_c();
  endtask

  initial begin
    rst_n = 1'b0;
    {ifa.start, ifa.sample_valid, ifa.sample_in, ifa.coef_in} = '0;
    {ifb.start, ifb.sample_valid, ifb.sample_in, ifb.coef_in} = '0;
    {ifc.start, ifc.sample_valid, ifc.sample_in, ifc.coef_in} = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_small_block();
    test_zero_block();
    test_continuous_valid();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_block();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
